serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_if.sv | 28 ++
 rtl/serial_subtractor.sv | 121 ++++++++++++
 tb/tb_serial_subtractor.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Bundle of the start/operand/result signals of serial_subtractor.
//   master : requester side - drives start, a, b, b_in; observes results.
//   slave  : the subtractor - observes the request; drives busy, done,
//            diff, b_out, ovf, zero.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b, b_in,
    input  busy, done, diff, b_out, ovf, zero
  );

  modport slave (
    input  start, a, b, b_in,
    output busy, done, diff, b_out, ovf, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in (mod 2^WIDTH), one bit per
// clock, LSB first. A start accepted in IDLE captures the operands, the
// block spends WIDTH cycles in RUN (busy=1), then one cycle in DONE
// (done=1). Results are registered on the edge entering DONE and held
// until the next completion or reset.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - serial_subtractor_if.slave: start, a, b, b_in in;
//          busy, done, diff, b_out, ovf, zero out
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  // Holds the WIDTH-1 bits already produced; the final bit is merged in
  // combinationally on the last RUN cycle, so no unused LSB is kept.
  logic [WIDTH-2:0] r_part;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_b_out;
  logic             r_ovf;
  logic             r_zero;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic [WIDTH-1:0] w_shift;
  logic             w_last;

  assign w_ai      = r_a[0];
  assign w_bi      = r_b[0];
  assign w_d       = w_ai ^ w_bi ^ r_br;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_shift   = {w_d, r_part};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_part  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_b_out <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_br    <= bus.b_in;
            r_cnt   <= '0;
            r_part  <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_br   <= w_br_next;
          r_part <= w_shift[WIDTH-1:1];
          r_cnt  <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_diff  <= w_shift;
            r_b_out <= w_br_next;
            // r_br is the borrow into the MSB position on this cycle.
            r_ovf   <= r_br ^ w_br_next;
            r_zero  <= (w_shift == '0);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.diff  = r_diff;
  assign bus.b_out = r_b_out;
  assign bus.ovf   = r_ovf;
  assign bus.zero  = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_results(input string tag, input logic [W-1:0] d,
                               input logic bo, input logic ov, input logic z);
    check({tag, ".diff"}, 32'(bus.diff), 32'(d));
    check({tag, ".b_out"}, 32'(bus.b_out), 32'(bo));
    check({tag, ".ovf"}, 32'(bus.ovf), 32'(ov));
    check({tag, ".zero"}, 32'(bus.zero), 32'(z));
  endtask

  // Start one operation, then garble operands after capture; check busy
  // for exactly W cycles, done in the following one, and held results.
  task automatic run_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    bus.a = v.a; bus.b = v.b; bus.b_in = v.bin; bus.start = 1'b1;
    for (int i = 1; i <= W + 2; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        bus.start = 1'b0;
        bus.a = ~v.a; bus.b = ~v.b; bus.b_in = ~v.bin;
      end
      check({tag, ".busy"}, 32'(bus.busy), 32'(i <= W));
      check({tag, ".done"}, 32'(bus.done), 32'(i == W + 1));
      if (i >= W + 1) check_results(tag, v.diff, v.bout, v.ovf, v.zero);
    end
  endtask

  vec_t vecs[$];
  int   first_done;
  int   second_done;
  int   done_cnt;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.b_in = 1'b0;

    vecs.push_back('{a: 4'd6,  b: 4'd3,  bin: 1'b0, diff: 4'h3, bout: 1'b0, ovf: 1'b0, zero: 1'b0});
    vecs.push_back('{a: 4'd3,  b: 4'd9,  bin: 1'b0, diff: 4'hA, bout: 1'b1, ovf: 1'b1, zero: 1'b0});
    vecs.push_back('{a: 4'd8,  b: 4'd1,  bin: 1'b0, diff: 4'h7, bout: 1'b0, ovf: 1'b1, zero: 1'b0});
    vecs.push_back('{a: 4'd5,  b: 4'd5,  bin: 1'b0, diff: 4'h0, bout: 1'b0, ovf: 1'b0, zero: 1'b1});
    vecs.push_back('{a: 4'd0,  b: 4'd0,  bin: 1'b1, diff: 4'hF, bout: 1'b1, ovf: 1'b0, zero: 1'b0});
    vecs.push_back('{a: 4'd5,  b: 4'd5,  bin: 1'b1, diff: 4'hF, bout: 1'b1, ovf: 1'b0, zero: 1'b0});
    vecs.push_back('{a: 4'd7,  b: 4'hF, bin: 1'b0, diff: 4'h8, bout: 1'b1, ovf: 1'b1, zero: 1'b0});
    vecs.push_back('{a: 4'hF, b: 4'hF, bin: 1'b0, diff: 4'h0, bout: 1'b0, ovf: 1'b0, zero: 1'b1});
    vecs.push_back('{a: 4'd9,  b: 4'd2,  bin: 1'b0, diff: 4'h7, bout: 1'b0, ovf: 1'b1, zero: 1'b0});

    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check_results("reset", '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vecs[k]) run_vec(vecs[k], $sformatf("vec%0d", k));

    // start during RUN with new operands must be ignored
    @(posedge clk); #1;
    bus.a = 4'd6; bus.b = 4'd3; bus.b_in = 1'b0; bus.start = 1'b1;
    done_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.start = 1'b0;
      if (i == 2) begin bus.a = 4'hF; bus.b = 4'h0; bus.b_in = 1'b1; bus.start = 1'b1; end
      if (i == 3) bus.start = 1'b0;
      if (bus.done) done_cnt++;
      if (i == W + 1) check_results("ignore", 4'h3, 1'b0, 1'b0, 1'b0);
      if (i > W + 1) check("ignore.busy", 32'(bus.busy), 32'd0);
    end
    check("ignore.done_count", 32'(done_cnt), 32'd1);

    // reset in the middle of RUN (results currently diff=3 from above)
    @(posedge clk); #1;
    bus.a = 4'd3; bus.b = 4'd9; bus.b_in = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("rstrun.busy_before", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstrun.busy", 32'(bus.busy), 32'd0);
    check("rstrun.done", 32'(bus.done), 32'd0);
    check_results("rstrun", '0, 1'b0, 1'b0, 1'b0);
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) done_cnt++;
    end
    check("rstrun.no_activity", 32'(done_cnt), 32'd0);
    run_vec(vecs[1], "after_rst");

    // reset and start in the same cycle: start is dropped
    @(posedge clk); #1;
    rst = 1'b1; bus.start = 1'b1; bus.a = 4'd6; bus.b = 4'd3; bus.b_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; bus.start = 1'b0;
    check("rst_start.busy0", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check("rst_start.busy1", 32'(bus.busy), 32'd0);

    // start held high: operations repeat every W+2 cycles
    bus.a = 4'd6; bus.b = 4'd3; bus.b_in = 1'b0; bus.start = 1'b1;
    first_done = -1;
    second_done = -1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        if (first_done < 0) first_done = c;
        else if (second_done < 0) second_done = c;
      end
    end
    bus.start = 1'b0;
    check("held.first_seen", 32'(first_done >= 0), 32'd1);
    check("held.period", 32'(second_done - first_done), 32'(W + 2));
    check_results("held", 4'h3, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
